// File: rtl/meu_cpu_pkg.sv
// Shared types and widths for the meu_cpu multicycle core.
package meu_cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_ADDI = 4'h6,
        OP_LI   = 4'h7,
        OP_LW   = 4'h8,
        OP_SW   = 4'h9,
        OP_BEQ  = 4'hA,
        OP_JMP  = 4'hB,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

endpackage

// File: rtl/meu_cpu_alu.sv
// Combinational ALU; any opcode it does not recognise passes operand B through (used by LI).
module meu_cpu_alu
    import meu_cpu_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [3:0]        op_i,
    output logic [DATA_W-1:0] y_o
);

    always_comb begin
        y_o = b_i;
        case (op_i)
            OP_ADD:  y_o = a_i + b_i;
            OP_SUB:  y_o = a_i - b_i;
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            default: y_o = b_i;
        endcase
    end

endmodule

// File: rtl/meu_cpu.sv
// 16-bit multicycle CPU: FETCH/DECODE/EXEC/MEM/WB/HALT control, 8x16 regfile, unified 256x16 memory.
// State | meaning: FETCH issue read at PC | DECODE latch IR, PC+1 | EXEC branch/jump | MEM load/store | WB reg write | HALT stop
module meu_cpu #(
    parameter int    DATA_W    = 16,
    parameter int    ADDR_W    = 8,
    parameter string INIT_FILE = "program.hex"
) (
    input  logic              Clk,
    input  logic              Reset,
    output logic [ADDR_W-1:0] dbg_pc,
    output logic [2:0]        dbg_state,
    output logic              halted
);
    import meu_cpu_pkg::*;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, mem_addr, eff_addr;
    logic [DATA_W-1:0] ir_q, ir_d, rdata_q;
    logic [DATA_W-1:0] regs_q [8];
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    logic [3:0]        op, alu_op;
    logic [2:0]        rd, rs, rt;
    logic [DATA_W-1:0] rd_val, rs_val, rt_val, imm6_ext, imm8_ext, alu_b, alu_y, rf_wdata;
    logic              mem_we, rf_we;

    assign op       = ir_q[15:12];
    assign rd       = ir_q[11:9];
    assign rs       = ir_q[8:6];
    assign rt       = ir_q[5:3];
    assign rd_val   = (rd == 3'd0) ? '0 : regs_q[rd];
    assign rs_val   = (rs == 3'd0) ? '0 : regs_q[rs];
    assign rt_val   = (rt == 3'd0) ? '0 : regs_q[rt];
    assign imm6_ext = {{(DATA_W-6){ir_q[5]}}, ir_q[5:0]};
    assign imm8_ext = {{(DATA_W-8){1'b0}}, ir_q[7:0]};
    assign eff_addr = ADDR_W'(rs_val + imm6_ext);

    // ADDI reuses the adder; LI rides the ALU's pass-B default.
    assign alu_op = (op == OP_ADDI) ? OP_ADD : op;

    always_comb begin
        alu_b = rt_val;
        case (op)
            OP_ADDI: alu_b = imm6_ext;
            OP_LI:   alu_b = imm8_ext;
            default: alu_b = rt_val;
        endcase
    end

    meu_cpu_alu u_alu (
        .a_i  (rs_val),
        .b_i  (alu_b),
        .op_i (alu_op),
        .y_o  (alu_y)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        mem_addr = pc_q;
        mem_we   = 1'b0;
        rf_we    = 1'b0;
        rf_wdata = alu_y;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                ir_d    = rdata_q;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_LI: state_d = S_WB;
                    OP_LW, OP_SW: state_d = S_MEM;
                    OP_BEQ:  if (rd_val == rs_val) pc_d = pc_q + imm6_ext[ADDR_W-1:0];
                    OP_JMP:  pc_d = ir_q[ADDR_W-1:0];
                    OP_HALT: state_d = S_HALT;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_addr = eff_addr;
                mem_we   = (op == OP_SW);
                state_d  = (op == OP_LW) ? S_WB : S_FETCH;
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_wdata = (op == OP_LW) ? rdata_q : alu_y;
                state_d  = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            if (rf_we && rd != 3'd0) regs_q[rd] <= rf_wdata;
        end
    end

    // Memory is not reset; during reset state_q is FETCH so no store can slip through.
    always_ff @(posedge Clk) begin
        if (mem_we) mem_q[mem_addr] <= rd_val;
        rdata_q <= mem_q[mem_addr];
    end

    assign dbg_pc    = pc_q;
    assign dbg_state = state_q;
    assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_meu_cpu.sv
// Bench for meu_cpu: directed ISA cases plus random programs against an instruction-level model.
module tb_meu_cpu;

    logic       Clk;
    logic       Reset;
    logic [7:0] dbg_pc;
    logic [2:0] dbg_state;
    logic       halted;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] img    [256];
    logic [15:0] m_mem  [256];
    logic [15:0] m_regs [8];
    int          m_pc;

    meu_cpu #(.DATA_W(16), .ADDR_W(8), .INIT_FILE("")) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .dbg_pc    (dbg_pc),
        .dbg_state (dbg_state),
        .halted    (halted)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc_r(input int op, input int rd, input int rs, input int rt);
        return {4'(op), 3'(rd), 3'(rs), 3'(rt), 3'b000};
    endfunction

    function automatic logic [15:0] enc_i(input int op, input int rd, input int rs, input int imm);
        return {4'(op), 3'(rd), 3'(rs), 6'(imm)};
    endfunction

    function automatic logic [15:0] enc_li(input int rd, input int imm8);
        return {4'h7, 3'(rd), 1'b0, 8'(imm8)};
    endfunction

    function automatic logic [15:0] enc_jmp(input int a);
        return {4'hB, 4'h0, 8'(a)};
    endfunction

    function automatic void clear_img();
        for (int i = 0; i < 256; i++) img[i] = 16'h0000;
    endfunction

    function automatic logic [15:0] rand_instr();
        int op;
        op = int'($urandom_range(0, 15));
        if (op == 15 && $urandom_range(0, 3) != 0) op = int'($urandom_range(1, 9));
        return {4'(op), 12'($urandom)};
    endfunction

    task automatic start_prog();
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 256; i++) dut.mem_q[i] <= img[i];
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        @(negedge Clk);
    endtask

    function automatic void m_wr(input int rd, input int v);
        if (rd != 0) m_regs[rd] = 16'(v);
    endfunction

    // Instruction-level interpreter: executes whole instructions and adds up their cycle cost.
    task automatic model_run(input int max_instr, output int cycles, output bit hlt);
        int pc, npc, a, b, d, imm6, addr, op, rd, rs, rt;
        logic [15:0] ins;
        for (int i = 0; i < 256; i++) m_mem[i] = img[i];
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
        pc = 0;
        cycles = 0;
        hlt = 1'b0;
        for (int n = 0; n < max_instr && !hlt; n++) begin
            ins  = m_mem[pc];
            op   = int'(ins[15:12]);
            rd   = int'(ins[11:9]);
            rs   = int'(ins[8:6]);
            rt   = int'(ins[5:3]);
            a    = int'(m_regs[rs]);
            b    = int'(m_regs[rt]);
            d    = int'(m_regs[rd]);
            imm6 = ins[5] ? int'(ins[5:0]) - 64 : int'(ins[5:0]);
            npc  = (pc + 1) % 256;
            addr = (a + imm6) & 255;
            case (op)
                1:  begin m_wr(rd, a + b);           cycles += 4; end
                2:  begin m_wr(rd, a - b);           cycles += 4; end
                3:  begin m_wr(rd, a & b);           cycles += 4; end
                4:  begin m_wr(rd, a | b);           cycles += 4; end
                5:  begin m_wr(rd, a ^ b);           cycles += 4; end
                6:  begin m_wr(rd, a + imm6);        cycles += 4; end
                7:  begin m_wr(rd, int'(ins[7:0]));  cycles += 4; end
                8:  begin m_wr(rd, int'(m_mem[addr])); cycles += 5; end
                9:  begin m_mem[addr] = 16'(d);      cycles += 4; end
                10: begin
                    if (d == a) npc = (npc + imm6) & 255;
                    cycles += 3;
                end
                11: begin npc = int'(ins[7:0]);      cycles += 3; end
                15: begin hlt = 1'b1;                cycles += 3; end
                default: cycles += 3;
            endcase
            pc = npc;
        end
        m_pc = pc;
    endtask

    initial begin
        int  cyc;
        bit  mh;

        // Asynchronous reset, mid-instruction
        Reset = 1'b0;
        clear_img();
        img[0] = enc_li(1, 5);
        img[1] = 16'hF000;
        for (int i = 0; i < 256; i++) dut.mem_q[i] <= img[i];
        #10 Reset = 1'b1;
        #19;
        chk("pre_rst_state", 32'(dbg_state), 2);
        chk("pre_rst_pc", 32'(dbg_pc), 1);
        #1 Reset = 1'b0;
        #1;
        chk("rst_state", 32'(dbg_state), 0);
        chk("rst_pc", 32'(dbg_pc), 0);
        chk("rst_ir", 32'(dut.ir_q), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_r1", 32'(dut.regs_q[1]), 0);

        // LI/LI/ADD/HALT: 15 cycles to HALT
        clear_img();
        img[0] = enc_li(1, 5);
        img[1] = enc_li(2, 7);
        img[2] = enc_r(1, 3, 1, 2);
        img[3] = 16'hF000;
        start_prog();
        step(14);
        chk("add_halt_early", 32'(halted), 0);
        step(1);
        chk("add_halted", 32'(halted), 1);
        chk("add_state", 32'(dbg_state), 5);
        chk("add_pc", 32'(dbg_pc), 4);
        chk("add_r3", 32'(dut.regs_q[3]), 12);
        step(5);
        chk("halt_hold", 32'(halted), 1);
        chk("halt_hold_pc", 32'(dbg_pc), 4);

        // SUB wraps
        img[2] = enc_r(2, 3, 1, 2);
        start_prog();
        step(15);
        chk("sub_r3", 32'(dut.regs_q[3]), 32'hFFFE);

        // SW then LW through a base register
        clear_img();
        img[0]     = enc_li(1, 8'h2A);
        img[1]     = enc_li(2, 8'h40);
        img[2]     = enc_i(9, 1, 2, 0);
        img[3]     = enc_i(8, 4, 2, 0);
        img[4]     = 16'hF000;
        img[8'h40] = 16'h1111;
        start_prog();
        step(12);
        chk("sw_mem", 32'(dut.mem_q[8'h40]), 32'h2A);
        chk("sw_state", 32'(dbg_state), 0);
        chk("sw_pc", 32'(dbg_pc), 3);
        step(4);
        chk("lw_wb_state", 32'(dbg_state), 4);
        chk("lw_r4_early", 32'(dut.regs_q[4]), 0);
        step(1);
        chk("lw_r4", 32'(dut.regs_q[4]), 32'h2A);
        chk("lw_pc", 32'(dbg_pc), 4);

        // Reset while SW sits in MEM: store must not happen
        img[8'h40] = 16'h1234;
        img[3]     = 16'hF000;
        start_prog();
        step(11);
        chk("abort_in_mem", 32'(dbg_state), 3);
        Reset = 1'b0;
        step(2);
        chk("abort_mem", 32'(dut.mem_q[8'h40]), 32'h1234);
        chk("abort_pc", 32'(dbg_pc), 0);
        chk("abort_state", 32'(dbg_state), 0);

        // BEQ taken / untaken
        clear_img();
        img[0] = enc_li(1, 3);
        img[1] = enc_li(2, 3);
        img[3] = enc_i(10, 1, 2, -4);
        start_prog();
        step(13);
        chk("beq_exec_pc", 32'(dbg_pc), 4);
        step(1);
        chk("beq_taken_pc", 32'(dbg_pc), 0);
        chk("beq_taken_state", 32'(dbg_state), 0);
        img[1] = enc_li(2, 4);
        start_prog();
        step(14);
        chk("beq_untaken_pc", 32'(dbg_pc), 4);

        // JMP to 0xFF, NOP there wraps PC to 0
        clear_img();
        img[0] = enc_jmp(8'hFF);
        start_prog();
        step(3);
        chk("jmp_pc", 32'(dbg_pc), 32'hFF);
        step(3);
        chk("wrap_pc", 32'(dbg_pc), 0);

        // r0 hard-wired to zero
        clear_img();
        img[0] = enc_li(5, 1);
        img[1] = enc_li(0, 9);
        img[2] = enc_r(1, 5, 0, 0);
        img[3] = 16'hF000;
        start_prog();
        step(15);
        chk("r0_halted", 32'(halted), 1);
        chk("r0_r0", 32'(dut.regs_q[0]), 0);
        chk("r0_r5", 32'(dut.regs_q[5]), 0);

        // Undefined opcode behaves as a 3-cycle NOP
        clear_img();
        img[0] = enc_li(1, 7);
        img[1] = 16'hCE48;
        img[2] = 16'hF000;
        start_prog();
        step(4);
        chk("undef_pre_pc", 32'(dbg_pc), 1);
        step(3);
        chk("undef_pc", 32'(dbg_pc), 2);
        chk("undef_state", 32'(dbg_state), 0);
        chk("undef_r1", 32'(dut.regs_q[1]), 7);
        chk("undef_r7", 32'(dut.regs_q[7]), 0);
        step(3);
        chk("undef_halted", 32'(halted), 1);

        // Random whole-memory programs against the interpreter
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 256; i++) img[i] = rand_instr();
            model_run(40, cyc, mh);
            start_prog();
            step(cyc);
            chk($sformatf("rnd%0d state", t), 32'(dbg_state), mh ? 5 : 0);
            chk($sformatf("rnd%0d pc", t), 32'(dbg_pc), 32'(m_pc));
            for (int r = 1; r < 8; r++)
                chk($sformatf("rnd%0d r%0d", t, r), 32'(dut.regs_q[r]), 32'(m_regs[r]));
            for (int i = 0; i < 256; i++)
                chk($sformatf("rnd%0d m%0h", t, i), 32'(dut.mem_q[i]), 32'(m_mem[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
